// File: rtl/loop_stack_unit.sv
// Loop-bracket stack for a '['/']' interpreter core: pushes loop heads, issues back-jumps, skips zero-trip bodies.
// Optional LOOP_STACK_HIGH_WATER_EN adds a high_water output tracking peak stack occupancy since reset.
module loop_stack_unit #(
  parameter int unsigned PC_WIDTH   = 10,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned SKIP_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       op_valid,
  input  logic [1:0]                 op,
  input  logic [PC_WIDTH-1:0]        pc_in,
  input  logic                       acc_zero,
  output logic                       ready,
  output logic                       skip,
  output logic                       jump,
  output logic [PC_WIDTH-1:0]        jump_pc,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       overflow,
  output logic                       underflow
`ifdef LOOP_STACK_HIGH_WATER_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] high_water
`endif
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_SKIP  = 2'd1;
  localparam logic [1:0] ST_ERROR = 2'd2;

  localparam logic [1:0] OP_OPEN  = 2'b01;
  localparam logic [1:0] OP_CLOSE = 2'b10;

  logic [1:0]            state, state_n;
  logic [SKIP_WIDTH-1:0] skip_cnt, skip_cnt_n;
  logic [DW-1:0]         depth_n;
  logic                  jump_n, overflow_n, underflow_n;
  logic [PC_WIDTH-1:0]   jump_pc_n;
  logic                  push_c;
  logic                  accept_c;
  logic [AW-1:0]         push_idx, top_idx;
  logic [PC_WIDTH-1:0]   stack [DEPTH];

  assign accept_c = op_valid & ready;
  assign push_idx = AW'(depth);
  assign top_idx  = AW'(depth - DW'(1));

  // Next-state and registered-output decode
  always_comb begin
    state_n     = state;
    skip_cnt_n  = skip_cnt;
    depth_n     = depth;
    jump_n      = 1'b0;
    jump_pc_n   = jump_pc;
    overflow_n  = overflow;
    underflow_n = underflow;
    push_c      = 1'b0;
    case (state)
      ST_RUN: begin
        if (accept_c && op == OP_OPEN) begin
          if (acc_zero) begin
            state_n    = ST_SKIP;
            skip_cnt_n = SKIP_WIDTH'(1);
          end else if (depth == DW'(DEPTH)) begin
            overflow_n = 1'b1;
            state_n    = ST_ERROR;
          end else begin
            push_c  = 1'b1;
            depth_n = depth + DW'(1);
          end
        end else if (accept_c && op == OP_CLOSE) begin
          if (depth == '0) begin
            underflow_n = 1'b1;
            state_n     = ST_ERROR;
          end else if (acc_zero) begin
            depth_n = depth - DW'(1);
          end else begin
            jump_n    = 1'b1;
            jump_pc_n = stack[top_idx] + PC_WIDTH'(1);
          end
        end
      end
      ST_SKIP: begin
        // Only bracket nesting matters while skipping; acc_zero is irrelevant
        if (accept_c && op == OP_OPEN) begin
          if (skip_cnt == '1) begin
            overflow_n = 1'b1;
            state_n    = ST_ERROR;
          end else begin
            skip_cnt_n = skip_cnt + SKIP_WIDTH'(1);
          end
        end else if (accept_c && op == OP_CLOSE) begin
          skip_cnt_n = skip_cnt - SKIP_WIDTH'(1);
          if (skip_cnt == SKIP_WIDTH'(1)) begin
            state_n = ST_RUN;
          end
        end
      end
      default: begin
        state_n = ST_ERROR;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      skip_cnt  <= '0;
      depth     <= '0;
      jump      <= 1'b0;
      jump_pc   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      skip      <= 1'b0;
      ready     <= 1'b1;
    end else begin
      state     <= state_n;
      skip_cnt  <= skip_cnt_n;
      depth     <= depth_n;
      jump      <= jump_n;
      jump_pc   <= jump_pc_n;
      overflow  <= overflow_n;
      underflow <= underflow_n;
      skip      <= (state_n == ST_SKIP);
      ready     <= (state_n != ST_ERROR);
    end
  end

  // Stack storage is not cleared by reset; occupancy alone defines validity
  always_ff @(posedge clk) begin
    if (!reset && push_c) begin
      stack[push_idx] <= pc_in;
    end
  end

`ifdef LOOP_STACK_HIGH_WATER_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      high_water <= '0;
    end else if (depth > high_water) begin
      high_water <= depth;
    end
  end
`endif

endmodule

// File: tb/tb_loop_stack_unit.sv
// Scoreboard bench for loop_stack_unit: driver queues expected post-op snapshots, monitor checks them.
// Define LOOP_STACK_HIGH_WATER_EN to also exercise the high_water output.
`timescale 1ns/1ps
module tb_loop_stack_unit;

  localparam logic [1:0] NOP = 2'b00, OPN = 2'b01, CLS = 2'b10, RSV = 2'b11;

  typedef struct packed {
    int unsigned stamp;
    int unsigned id;
    logic        jump;
    logic        chk_pc;
    logic [9:0]  jpc;
    logic [3:0]  depth;
    logic        skip;
    logic        ready;
    logic        ovf;
    logic        unf;
    logic        chk_hw;
    logic [3:0]  hw;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       op_valid = 1'b0;
  logic [1:0] op = 2'b00;
  logic [9:0] pc_in = '0;
  logic       acc_zero = 1'b0;
  logic       ready, skip, jump, overflow, underflow;
  logic [9:0] jump_pc;
  logic [3:0] depth;
  logic [3:0] high_water;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned next_id = 0;

  loop_stack_unit #(.PC_WIDTH(10), .DEPTH(8), .SKIP_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .pc_in(pc_in),
    .acc_zero(acc_zero), .ready(ready), .skip(skip), .jump(jump),
    .jump_pc(jump_pc), .depth(depth), .overflow(overflow), .underflow(underflow)
`ifdef LOOP_STACK_HIGH_WATER_EN
    , .high_water(high_water)
`endif
  );

`ifndef LOOP_STACK_HIGH_WATER_EN
  assign high_water = '0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic j, input logic [9:0] jpc, input logic [3:0] d,
                              input logic s, input logic r, input logic o, input logic u);
    exp_t e;
    e = '0;
    e.jump = j; e.chk_pc = j; e.jpc = jpc; e.depth = d;
    e.skip = s; e.ready = r; e.ovf = o; e.unf = u;
    return e;
  endfunction

  task automatic push_exp(input exp_t e);
    e.stamp = cyc + 1;
    e.id    = next_id;
    next_id = next_id + 1;
    q.push_back(e);
  endtask

  task automatic do_op(input logic v, input logic [1:0] o, input logic [9:0] pc,
                       input logic az, input exp_t e);
    @(negedge clk);
    reset = 1'b0; op_valid = v; op = o; pc_in = pc; acc_zero = az;
    push_exp(e);
  endtask

  // Reset asserted together with a CLOSE to show reset wins over the op
  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    reset = 1'b1; op_valid = 1'b1; op = CLS; pc_in = '0; acc_zero = 1'b0;
    e = mk(1'b0, 10'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    e.chk_pc = 1'b1;
    push_exp(e);
  endtask

  // Monitor: compare the queued snapshot due this cycle; flag any unexpected jump pulse
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0 && q[0].stamp == cyc) begin
        exp_t e;
        logic ok;
        e  = q.pop_front();
        ok = (jump === e.jump) && (depth === e.depth) && (skip === e.skip) &&
             (ready === e.ready) && (overflow === e.ovf) && (underflow === e.unf) &&
             (!e.chk_pc || jump_pc === e.jpc) && (!e.chk_hw || high_water === e.hw);
        n_cmp = n_cmp + 1;
        if (!ok) begin
          n_bad = n_bad + 1;
          $display("FAIL step%0d: got j=%b pc=%0d d=%0d s=%b r=%b o=%b u=%b hw=%0d, want j=%b pc=%0d d=%0d s=%b r=%b o=%b u=%b hw=%0d",
                   e.id, jump, jump_pc, depth, skip, ready, overflow, underflow, high_water,
                   e.jump, e.jpc, e.depth, e.skip, e.ready, e.ovf, e.unf, e.hw);
        end
      end else if (jump === 1'b1) begin
        n_cmp = n_cmp + 1;
        n_bad = n_bad + 1;
        $display("FAIL stray_jump: got jump=1 pc=%0d at cycle %0d, want jump=0", jump_pc, cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    do_reset();
    // Open at 5, repeated back-jumps to 6, then exit
    do_op(1, OPN, 10'd5, 0, mk(0, 0, 1, 0, 1, 0, 0));
    do_op(1, CLS, 10'd9, 0, mk(1, 10'd6, 1, 0, 1, 0, 0));
    do_op(1, CLS, 10'd9, 0, mk(1, 10'd6, 1, 0, 1, 0, 0));
    do_op(1, NOP, 10'd7, 1, mk(0, 0, 1, 0, 1, 0, 0));
    do_op(1, RSV, 10'd7, 1, mk(0, 0, 1, 0, 1, 0, 0));
    do_op(0, CLS, 10'd9, 1, mk(0, 0, 1, 0, 1, 0, 0));
    do_op(1, CLS, 10'd9, 1, mk(0, 0, 0, 0, 1, 0, 0));
    // Zero-trip loop with a nested body
    do_op(1, OPN, 10'd10, 1, mk(0, 0, 0, 1, 1, 0, 0));
    do_op(1, OPN, 10'd11, 0, mk(0, 0, 0, 1, 1, 0, 0));
    do_op(1, RSV, 10'd12, 0, mk(0, 0, 0, 1, 1, 0, 0));
    do_op(1, CLS, 10'd13, 0, mk(0, 0, 0, 1, 1, 0, 0));
    do_op(1, CLS, 10'd14, 0, mk(0, 0, 0, 0, 1, 0, 0));
    do_op(0, OPN, 10'd15, 0, mk(0, 0, 0, 0, 1, 0, 0));
    // Jump target wraps modulo 2^10
    do_op(1, OPN, 10'd1023, 0, mk(0, 0, 1, 0, 1, 0, 0));
    do_op(1, CLS, 10'd3, 0, mk(1, 10'd0, 1, 0, 1, 0, 0));
    do_op(1, CLS, 10'd3, 1, mk(0, 0, 0, 0, 1, 0, 0));
    // Nested loops jump to the innermost head
    do_op(1, OPN, 10'd20, 0, mk(0, 0, 1, 0, 1, 0, 0));
    do_op(1, OPN, 10'd30, 0, mk(0, 0, 2, 0, 1, 0, 0));
    do_op(1, CLS, 10'd40, 0, mk(1, 10'd31, 2, 0, 1, 0, 0));
    do_op(1, CLS, 10'd40, 1, mk(0, 0, 1, 0, 1, 0, 0));
    do_op(1, CLS, 10'd50, 0, mk(1, 10'd21, 1, 0, 1, 0, 0));
    do_op(1, CLS, 10'd50, 1, mk(0, 0, 0, 0, 1, 0, 0));
    // Stack overflow
    for (int i = 0; i < 8; i++)
      do_op(1, OPN, 10'(100 + i), 0, mk(0, 0, 4'(i + 1), 0, 1, 0, 0));
    do_op(1, OPN, 10'd200, 0, mk(0, 0, 8, 0, 0, 1, 0));
    do_op(1, CLS, 10'd201, 0, mk(0, 0, 8, 0, 0, 1, 0));
    do_reset();
    // Underflow
    do_op(1, CLS, 10'd5, 0, mk(0, 0, 0, 0, 0, 0, 1));
    do_op(1, OPN, 10'd6, 0, mk(0, 0, 0, 0, 0, 0, 1));
    do_reset();
    // Skip counter saturation
    do_op(1, OPN, 10'd1, 1, mk(0, 0, 0, 1, 1, 0, 0));
    for (int i = 0; i < 254; i++)
      do_op(1, OPN, 10'd2, 0, mk(0, 0, 0, 1, 1, 0, 0));
    do_op(1, OPN, 10'd3, 0, mk(0, 0, 0, 0, 0, 1, 0));
    do_op(1, CLS, 10'd4, 0, mk(0, 0, 0, 0, 0, 1, 0));
    // Reset from mid-skip
    do_reset();
    do_op(1, OPN, 10'd1, 1, mk(0, 0, 0, 1, 1, 0, 0));
    do_reset();
    do_op(1, NOP, 10'd0, 0, mk(0, 0, 0, 0, 1, 0, 0));
`ifdef LOOP_STACK_HIGH_WATER_EN
    for (int i = 0; i < 3; i++)
      do_op(1, OPN, 10'(60 + i), 0, mk(0, 0, 4'(i + 1), 0, 1, 0, 0));
    for (int i = 0; i < 3; i++)
      do_op(1, CLS, 10'd70, 1, mk(0, 0, 4'(2 - i), 0, 1, 0, 0));
    do_op(1, OPN, 10'd80, 0, mk(0, 0, 1, 0, 1, 0, 0));
    e = mk(0, 0, 1, 0, 1, 0, 0);
    e.chk_hw = 1'b1; e.hw = 4'd3;
    do_op(1, NOP, 10'd0, 0, e);
`endif
    @(negedge clk);
    op_valid = 1'b0;
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
